alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle arithmetic sequencer that drives the shared 8-bit ROM-decoded ALU to compute an 8×8 unsigned multiply, and optionally an 8÷8 unsigned divide. It sits between the control unit and the ALU: it owns the ALU inputs while busy and releases them (output-enable low) when idle. Shift-add multiply and restoring divide use one ALU operation per cycle. Shifting of the partial result is done internally.

## Interface
- `OP_ADD`, default 8'h00: ALU ROM address (cins) selecting A + B + carry-in, with carry gating enabled.
- `OP_SUB`, default 8'h01: ALU ROM address selecting A + ~B + carry-in, with carry gating enabled.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `op` in 1: operation select. 0 = multiply, 1 = divide.
- `opa` in 8: multiplicand or dividend.
- `opb` in 8: multiplier or divisor.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse; `result` is valid at and after this pulse.
- `err` out 1: valid with `done`. Indicates divide by zero or an unsupported op.
- `result` out 16: multiply gives the product. Divide gives {remainder[15:8], quotient[7:0]}.
- `alu_a` out 8: ALU A operand.
- `alu_b` out 8: ALU B operand.
- `alu_cins` out 8: ALU ROM address.
- `alu_oe` out 1: ALU output enable.
- `alu_carryin` out 1: ALU carry-in.
- `alu_out` in 8: ALU result, combinational from the `alu_*` outputs.
- `alu_carryout` in 1: ALU adder carry-out.

## Operation
**States:** IDLE, RUN, DONE. On `rst`, all registers clear, state goes to IDLE, and every output is 0.

**IDLE**
- `alu_oe` = 0, `alu_cins` = 0.
- `start` = 1 latches `opa`, `opb` and `op`, and sets cnt = 0.
- Multiply: hi = 0, lo = `opb`, mc = `opa`. Next state is RUN.
- Divide with `opb` = 0: `err` is set and `result` = {`opa`, 8'hFF}. Next state is DONE.

**RUN, multiply (8 iterations)**
- ALU inputs: a = hi, b = mc, `cins` = `OP_ADD`, `carryin` = 0, `oe` = 1.
- If lo[0] = 1: {hi,lo} ← {`alu_carryout`, `alu_out`, lo} >> 1.
- Otherwise: {hi,lo} ← {1'b0, hi, lo} >> 1.
- The ALU is driven every cycle; the result is simply discarded when lo[0] = 0.

**RUN, divide (8 iterations; rem = 8 bit, q = dividend/quotient shift register)**
- Shifted remainder: s = {rem, q[7]}, 9 bits.
- ALU inputs: a = s[7:0], b = divisor, `cins` = `OP_SUB`, `carryin` = 1.
- If s[8] | `alu_carryout`: rem ← `alu_out`, q ← {q[6:0], 1}.
- Otherwise: rem ← s[7:0], q ← {q[6:0], 0}.

**Sequencing**
- cnt increments every RUN cycle. RUN → DONE when cnt = 7.

**DONE**
- `done` = 1 for exactly one cycle, `busy` = 1, `alu_oe` = 0.
- Next state is IDLE.
- `result` and `err` hold until the next accepted `start` or `rst`.

**Boundary rules**
- `start` is ignored in RUN and DONE. It is never queued.
- `op` and operand changes after acceptance have no effect.
- `rst` during RUN or DONE aborts immediately. No `done` pulse is produced and `result` = 0.
- An accepted `start` clears `err` and `result` on the same edge.

## Timing
- Start accepted at edge 0. RUN occupies cycles 1–8. `done` pulses in cycle 9. Back-to-back ops: next `start` is accepted in cycle 10 at the earliest. Throughput is 1 op per 10 cycles.
- Divide-by-zero and unsupported op: `done` in cycle 1.
- The ALU path is combinational within one cycle. The `alu_*` outputs are decoded from registered state only; they have no combinational path from `start`, `opa` or `opb`.
- `busy` rises in cycle 1 and falls in cycle 10.

## Configuration
- `ALU_SEQ_DIV_EN` defined: divide is supported as specified.
- Undefined: the divide datapath and `OP_SUB` usage are compiled out. An accepted `start` with `op` = 1 goes straight to DONE with `err` = 1 and `result` = 0, so `done` arrives in cycle 1. The `OP_SUB` parameter remains declared but unused.

## Test plan
- Multiply 13 × 11 → `done` in cycle 9, `result` = 16'h008F, `err` = 0. Multiply 255 × 255 → 16'hFE01. Multiply 0 × 200 → 16'h0000.
- Divide 200 ÷ 7 (DIV_EN) → `result` = 16'h041C. Divide 255 ÷ 1 → 16'h00FF. Divide 5 ÷ 9 → 16'h0500.
- Divide 77 ÷ 0 → `done` in cycle 1, `err` = 1, `result` = 16'h4DFF. Without DIV_EN, any divide → `err` = 1, `result` = 0.
- Pulse `start` during cycles 3 and 9 of a 13 × 11 multiply → ignored; a single `done`, still 16'h008F.
- Assert `rst` in cycle 5 → next cycle `busy` = `done` = 0, `result` = 0, `alu_oe` = 0; no later `done`.
- Check `alu_oe` = 1 only in cycles 1–8, with `alu_cins` = `OP_ADD` (multiply) or `OP_SUB` (divide).

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle sequencer that drives the shared 8-bit ALU: shift-add 8x8 multiply,
// plus restoring 8/8 divide when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter logic [7:0] OP_ADD = 8'h00,
  parameter logic [7:0] OP_SUB = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [7:0]  opa,
  input  logic [7:0]  opb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_cins,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic [7:0]  alu_out,
  input  logic        alu_carryout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] hi;   // multiply: product high byte / divide: remainder
  logic [7:0] lo;   // multiply: multiplier/product low byte / divide: quotient
  logic [7:0] mc;   // multiplicand or divisor
  logic [2:0] cnt;
  logic [7:0] nhi, nlo;

`ifdef ALU_SEQ_DIV_EN
  logic is_div;
`else
  logic unused_sub;
  assign unused_sub = ^OP_SUB;
`endif

  // ALU drive is decoded purely from registered state.
  always_comb begin
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_cins    = 8'h00;
    alu_oe      = 1'b0;
    alu_carryin = 1'b0;
    if (state == RUN) begin
      alu_oe   = 1'b1;
      alu_b    = mc;
      alu_a    = hi;
      alu_cins = OP_ADD;
`ifdef ALU_SEQ_DIV_EN
      if (is_div) begin
        alu_a       = {hi[6:0], lo[7]};
        alu_cins    = OP_SUB;
        alu_carryin = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    nhi = {1'b0, hi[7:1]};
    nlo = {hi[0], lo[7:1]};
    if (lo[0]) begin
      nhi = {alu_carryout, alu_out[7:1]};
      nlo = {alu_out[0], lo[7:1]};
    end
`ifdef ALU_SEQ_DIV_EN
    if (is_div) begin
      // Shifted remainder bit 8 set means it always exceeds the divisor.
      if (hi[7] | alu_carryout) begin
        nhi = alu_out;
        nlo = {lo[6:0], 1'b1};
      end else begin
        nhi = {hi[6:0], lo[7]};
        nlo = {lo[6:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hi     <= 8'h00;
      lo     <= 8'h00;
      mc     <= 8'h00;
      cnt    <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= 16'h0000;
`ifdef ALU_SEQ_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err    <= 1'b0;
            result <= 16'h0000;
            cnt    <= 3'd0;
            busy   <= 1'b1;
            hi     <= 8'h00;
            lo     <= opb;
            mc     <= opa;
            state  <= RUN;
`ifdef ALU_SEQ_DIV_EN
            is_div <= op;
            if (op) begin
              lo <= opa;
              mc <= opb;
              if (opb == 8'h00) begin
                err    <= 1'b1;
                result <= {opa, 8'hFF};
                done   <= 1'b1;
                state  <= DONE;
              end
            end
`else
            if (op) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
`endif
          end
        end
        RUN: begin
          hi  <= nhi;
          lo  <= nlo;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            result <= {nhi, nlo};
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU, vector table, hand-written
// corner sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;
  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [7:0]  opa, opb;
  logic        busy, done, err;
  logic [15:0] result;
  logic [7:0]  alu_a, alu_b, alu_cins, alu_out;
  logic        alu_oe, alu_carryin, alu_carryout;
  logic [8:0]  alu_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .err(err), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cins(alu_cins), .alu_oe(alu_oe),
    .alu_carryin(alu_carryin), .alu_out(alu_out), .alu_carryout(alu_carryout)
  );

  // Shared ALU model: only the two ROM entries the sequencer uses.
  always_comb begin
    alu_sum = 9'h000;
    if (alu_cins == OP_ADD)
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carryin};
    else if (alu_cins == OP_SUB)
      alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_carryin};
  end
  assign alu_out      = alu_sum[7:0];
  assign alu_carryout = alu_sum[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [7:0] a, input logic [7:0] b,
                                output logic [15:0] res, output logic e, output int lat);
    logic [7:0] q, r;
    e = 1'b0; lat = 9;
    if (!o) begin
      res = 16'(int'(a) * int'(b));
    end else begin
`ifdef ALU_SEQ_DIV_EN
      if (b == 8'h00) begin
        res = {a, 8'hFF}; e = 1'b1; lat = 1;
      end else begin
        q = 8'(int'(a) / int'(b));
        r = 8'(int'(a) % int'(b));
        res = {r, q};
      end
`else
      res = 16'h0000; e = 1'b1; lat = 1;
`endif
    end
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge after done.
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] res, output logic e, output int lat,
                        output int oe_n, output int cins_bad);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; opa = 8'($urandom); opb = 8'($urandom);
    lat = 0; oe_n = 0; cins_bad = 0; res = 16'h0; e = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (alu_oe) begin
        oe_n++;
        if (alu_cins != (o ? OP_SUB : OP_ADD)) cins_bad++;
      end
      if (done) begin
        lat = c; res = result; e = err;
      end
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(res));
  endtask

  typedef struct packed {
    logic        op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
    logic [4:0]  lat;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] r, mres;
  logic        e, merr;
  int          lat, oe_n, cins_bad, mlat, ndone;

  initial begin
    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'h008F, 1'b0, 5'd9};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01, 1'b0, 5'd9};
    vecs[2] = '{1'b0, 8'd0,   8'd200, 16'h0000, 1'b0, 5'd9};
`ifdef ALU_SEQ_DIV_EN
    vecs[3] = '{1'b1, 8'd200, 8'd7,   16'h041C, 1'b0, 5'd9};
    vecs[4] = '{1'b1, 8'd255, 8'd1,   16'h00FF, 1'b0, 5'd9};
    vecs[5] = '{1'b1, 8'd5,   8'd9,   16'h0500, 1'b0, 5'd9};
    vecs[6] = '{1'b1, 8'd77,  8'd0,   16'h4DFF, 1'b1, 5'd1};
`else
    vecs[3] = '{1'b1, 8'd200, 8'd7,   16'h0000, 1'b1, 5'd1};
    vecs[4] = '{1'b1, 8'd255, 8'd1,   16'h0000, 1'b1, 5'd1};
    vecs[5] = '{1'b1, 8'd5,   8'd9,   16'h0000, 1'b1, 5'd1};
    vecs[6] = '{1'b1, 8'd77,  8'd0,   16'h0000, 1'b1, 5'd1};
`endif

    rst = 1'b1; start = 1'b0; op = 1'b0; opa = 8'h00; opb = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_err",    32'(err),    32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_alu",    {alu_a, alu_b, alu_cins, 5'd0, alu_oe, alu_carryin, 1'b0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, e, lat, oe_n, cins_bad);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_oe_cycles", i), 32'(oe_n), (vecs[i].lat == 5'd9) ? 32'd8 : 32'd0);
      chk($sformatf("vec%0d_cins", i), 32'(cins_bad), 32'd0);
    end

    // start pulses in cycles 3 and 9 must be ignored
    start = 1'b1; op = 1'b0; opa = 8'd13; opb = 8'd11;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; r = 16'h0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin ndone++; r = result; end
      if (c == 3 || c == 9) begin start = 1'b1; op = 1'b0; opa = 8'd2; opb = 8'd2; end
      else start = 1'b0;
    end
    chk("ignore_start_ndone",  32'(ndone), 32'd1);
    chk("ignore_start_result", 32'(r), 32'h008F);
    chk("ignore_start_idle",   32'(busy), 32'd0);

    // reset in cycle 5 aborts with no done
    start = 1'b1; op = 1'b0; opa = 8'd13; opb = 8'd11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_done",   32'(done),   32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_oe",     32'(alu_oe), 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic       ro;
      logic [7:0] ra, rb;
      ro = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      model(ro, ra, rb, mres, merr, mlat);
      run_op(ro, ra, rb, r, e, lat, oe_n, cins_bad);
      chk($sformatf("rnd%0d_result op=%0d a=%0d b=%0d", i, ro, ra, rb), 32'(r), 32'(mres));
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(merr));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_cins", i), 32'(cins_bad), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
